buzzer_morse_player: RTL and testbench
======================================

// Module: buzzer_morse_player
// PURPOSE
//  Read side of the buzzer command FIFO. Pops one byte at a time and plays it on the buzzer pin as Morse code.
//  Supported codes: 'A'-'Z', '0'-'9', space (word gap) and 0x1B (attention tone).
//  Sits between the buzzer interface FIFO (read port) and the board buzzer pin.
// PARAMETERS
//  UNIT_CYCLES  5_000_000  one Morse time unit in CLK cycles (100 ms @ 50 MHz); >=2
//  TONE_HALF    12_500     tone half-period in CLK cycles (2 kHz @ 50 MHz); >=1
// PORTS
//  CLK             in   1  system clock, single clock domain
//  RST             in   1  synchronous, active-high reset
//  Empty_Sig       in   1  FIFO empty flag
//  FIFO_Read_Data  in   8  FIFO read data; valid the cycle after Read_Req_Sig (non-show-ahead)
//  Read_Req_Sig    out  1  FIFO read request, one-cycle pulse
//  Busy_Sig        out  1  high from pop until the end of the byte's trailing gap
//  Pin_Out         out  1  buzzer drive
// BEHAVIOUR
//  Reset (sync, RST=1 at a CLK edge): Read_Req_Sig=0, Busy_Sig=0, Pin_Out=0, state=IDLE, all counters 0.
//  FSM states: IDLE, POP, LOAD, TONE, GAP.
//  IDLE: if !Empty_Sig, set Read_Req_Sig=1 for exactly 1 cycle and go to POP. Otherwise stay.
//  POP: Read_Req_Sig=0; wait 1 cycle for data.
//  LOAD: latch FIFO_Read_Data and look it up. Results:
//    letter/digit -> len 1..5, pattern bits (1=dash); elements play MSB-first from bit len-1.
//    0x1B -> one 10-unit tone.  0x20 -> 7-unit silence.  Any other byte -> consumed silently, back to IDLE.
//  Cycle at t: Read_Req_Sig high at t, data sampled at t+2 (LOAD), first tone cycle t+3.
//  TONE: dot = 1 unit, dash = 3 units. Pin_Out toggles every TONE_HALF cycles.
//    Tone phase restarts at 0, and Pin_Out is 1 on the first tone cycle.
//  GAP: Pin_Out=0. After a non-final element: 1 unit. After the final element or 0x1B: 3 units.
//    Space: 7 units total, no tone. At GAP end go to IDLE.
//  Busy_Sig high in POP/LOAD/TONE/GAP; low only in IDLE.
//  Empty_Sig is ignored outside IDLE: no prefetch, at most one byte in flight.
//  Unit counter: 0..UNIT_CYCLES-1 wraps. Element counter is 3 bits. All counters saturate-free, reloaded on each state entry.
//  Reset mid-byte: the byte is discarded and Pin_Out=0 the next cycle. No further FIFO read until RST drops.
// CONFIGURATION
//  BUZZER_DC_TONE_EN defined: Pin_Out is held 1 for the whole TONE state, for an active (self-oscillating) buzzer.
//    TONE_HALF is unused.
//  Undefined (default): square wave as above, for a passive buzzer.
//  Timing of states is identical either way.
// STRUCTURE
//  buzzer_pkg: state encoding, char constants (CH_ESC=8'h1B, CH_SPACE=8'h20).
//    Also unit multiples DOT_U=1, DASH_U=3, ELEM_GAP_U=1, CHAR_GAP_U=3, WORD_GAP_U=7, ATTN_U=10.
//  buzzer_morse_rom: combinational sub-module. 8-bit code -> {valid, len[2:0], pattern[4:0]}.
//  Top holds the FSM, unit/tone counters and pin driver.
// TESTING  (UNIT_CYCLES=8, TONE_HALF=2)
//  1. FIFO holds 'E'(8'h45): 1 read pulse; 8 tone cycles (Pin_Out 1,1,0,0,1,1,0,0); 24 cycles low; Busy_Sig falls; next read only then.
//  2. 'D'(8'h44): tone 24 / low 8 / tone 8 / low 8 / tone 8 / low 24. Exactly one Read_Req_Sig pulse.
//  3. Sequence 8'h1B,8'h44,8'h1B: 80 tone + 24 low, then D as in 2, then 80 tone + 24 low. Three read pulses total.
//  4. 8'h20 then 8'h7E: 56 cycles Pin_Out=0, Busy high. 8'h7E popped, Busy high 2 cycles, no tone.
//  5. Empty_Sig held 1 for 100 cycles: Read_Req_Sig, Busy_Sig, Pin_Out stay 0.
//  6. RST pulsed mid-dash of 'T': Pin_Out=0 and Busy_Sig=0 next cycle. After release with FIFO empty, no read is issued.
//  Repeat 1 and 2 with BUZZER_DC_TONE_EN: Pin_Out is a solid 1 during each tone window.

Source files
------------

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the Morse buzzer player: FSM states,
// special command bytes, timing multiples and the code-table entry layout.
package buzzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LOAD,
    ST_TONE,
    ST_GAP
  } state_t;

  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_SPACE = 8'h20;

  // Durations in Morse time units
  localparam int DOT_U      = 1;
  localparam int DASH_U     = 3;
  localparam int ELEM_GAP_U = 1;
  localparam int CHAR_GAP_U = 3;
  localparam int WORD_GAP_U = 7;
  localparam int ATTN_U     = 10;

  // Wide enough for the longest duration (ATTN_U)
  localparam int UNITS_W = 4;

  // pattern is right-aligned; element i is pattern[i], 1 = dash, played from bit len-1 down
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pattern;
  } morse_code_t;

  function automatic logic [UNITS_W-1:0] elem_units(input logic dash);
    return dash ? UNITS_W'(DASH_U) : UNITS_W'(DOT_U);
  endfunction

  function automatic morse_code_t morse_entry(input logic [2:0] len, input logic [4:0] pattern);
    morse_code_t e;
    e.valid   = 1'b1;
    e.len     = len;
    e.pattern = pattern;
    return e;
  endfunction

endpackage

// File: rtl/buzzer_morse_rom.sv
// Combinational Morse code table: uppercase letters and digits map to
// {valid, len, pattern}; every other byte returns valid=0.
module buzzer_morse_rom
  import buzzer_pkg::*;
(
  input  logic [7:0]  code_i,
  output morse_code_t entry_o
);

  always_comb begin
    entry_o = '0;
    case (code_i)
      8'h41: entry_o = morse_entry(3'd2, 5'b00001); // A .-
      8'h42: entry_o = morse_entry(3'd4, 5'b01000); // B -...
      8'h43: entry_o = morse_entry(3'd4, 5'b01010);
      8'h44: entry_o = morse_entry(3'd3, 5'b00100);
      8'h45: entry_o = morse_entry(3'd1, 5'b00000);
      8'h46: entry_o = morse_entry(3'd4, 5'b00010);
      8'h47: entry_o = morse_entry(3'd3, 5'b00110);
      8'h48: entry_o = morse_entry(3'd4, 5'b00000);
      8'h49: entry_o = morse_entry(3'd2, 5'b00000);
      8'h4A: entry_o = morse_entry(3'd4, 5'b00111);
      8'h4B: entry_o = morse_entry(3'd3, 5'b00101);
      8'h4C: entry_o = morse_entry(3'd4, 5'b00100);
      8'h4D: entry_o = morse_entry(3'd2, 5'b00011);
      8'h4E: entry_o = morse_entry(3'd2, 5'b00010);
      8'h4F: entry_o = morse_entry(3'd3, 5'b00111);
      8'h50: entry_o = morse_entry(3'd4, 5'b00110);
      8'h51: entry_o = morse_entry(3'd4, 5'b01101);
      8'h52: entry_o = morse_entry(3'd3, 5'b00010);
      8'h53: entry_o = morse_entry(3'd3, 5'b00000);
      8'h54: entry_o = morse_entry(3'd1, 5'b00001);
      8'h55: entry_o = morse_entry(3'd3, 5'b00001);
      8'h56: entry_o = morse_entry(3'd4, 5'b00001);
      8'h57: entry_o = morse_entry(3'd3, 5'b00011);
      8'h58: entry_o = morse_entry(3'd4, 5'b01001);
      8'h59: entry_o = morse_entry(3'd4, 5'b01011);
      8'h5A: entry_o = morse_entry(3'd4, 5'b01100);
      8'h30: entry_o = morse_entry(3'd5, 5'b11111);
      8'h31: entry_o = morse_entry(3'd5, 5'b01111);
      8'h32: entry_o = morse_entry(3'd5, 5'b00111);
      8'h33: entry_o = morse_entry(3'd5, 5'b00011);
      8'h34: entry_o = morse_entry(3'd5, 5'b00001);
      8'h35: entry_o = morse_entry(3'd5, 5'b00000);
      8'h36: entry_o = morse_entry(3'd5, 5'b10000);
      8'h37: entry_o = morse_entry(3'd5, 5'b11000);
      8'h38: entry_o = morse_entry(3'd5, 5'b11100);
      8'h39: entry_o = morse_entry(3'd5, 5'b11110);
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/buzzer_morse_player.sv
// Pops bytes from the buzzer FIFO and plays them as Morse code on Pin_Out.
// Define BUZZER_DC_TONE_EN to hold Pin_Out high during tones (active buzzer).
module buzzer_morse_player
  import buzzer_pkg::*;
#(
  parameter int UNIT_CYCLES = 5_000_000,
  parameter int TONE_HALF   = 12_500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Empty_Sig,
  input  logic [7:0] FIFO_Read_Data,
  output logic       Read_Req_Sig,
  output logic       Busy_Sig,
  output logic       Pin_Out
);

  localparam int                UNIT_W    = (UNIT_CYCLES > 2) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(UNIT_CYCLES - 1);

`ifndef BUZZER_DC_TONE_EN
  localparam int                TONE_W    = $clog2(TONE_HALF + 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
`endif

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               busy_q, busy_d;
  logic               pin_q, pin_d;
  logic [UNIT_W-1:0]  unit_cnt_q, unit_cnt_d;
  logic [UNITS_W-1:0] units_q, units_d;
  logic [2:0]         elem_q, elem_d;
  logic [4:0]         pat_q, pat_d;

  morse_code_t rom_entry;
  logic        unit_last;
  logic        elem_last;
  logic [2:0]  load_msb;
  logic [2:0]  next_elem;

  buzzer_morse_rom u_rom (
    .code_i  (FIFO_Read_Data),
    .entry_o (rom_entry)
  );

  always_comb begin
    unit_last  = (unit_cnt_q == UNIT_LAST);
    elem_last  = unit_last && (units_q == UNITS_W'(1));
    load_msb   = rom_entry.len - 3'd1;
    next_elem  = elem_q - 3'd1;

    state_d    = state_q;
    req_d      = 1'b0;
    pin_d      = pin_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    elem_d     = elem_q;
    pat_d      = pat_q;
`ifndef BUZZER_DC_TONE_EN
    tone_cnt_d = tone_cnt_q;
`endif

    // units_q counts the whole units still to play in the current state
    if (state_q == ST_TONE || state_q == ST_GAP) begin
      if (unit_last) begin
        unit_cnt_d = '0;
        units_d    = units_q - UNITS_W'(1);
      end else begin
        unit_cnt_d = unit_cnt_q + UNIT_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        pin_d = 1'b0;
        // The request pulse is issued from IDLE; POP follows once it has been seen
        if (req_q) begin
          state_d = ST_POP;
        end else if (!Empty_Sig) begin
          req_d = 1'b1;
        end
      end

      ST_POP: state_d = ST_LOAD;

      ST_LOAD: begin
        unit_cnt_d = '0;
        pat_d      = rom_entry.pattern;
`ifndef BUZZER_DC_TONE_EN
        tone_cnt_d = '0;
`endif
        if (FIFO_Read_Data == CH_ESC) begin
          state_d = ST_TONE;
          units_d = UNITS_W'(ATTN_U);
          elem_d  = 3'd0;
          pin_d   = 1'b1;
        end else if (FIFO_Read_Data == CH_SPACE) begin
          state_d = ST_GAP;
          units_d = UNITS_W'(WORD_GAP_U);
          elem_d  = 3'd0;
          pin_d   = 1'b0;
        end else if (rom_entry.valid) begin
          state_d = ST_TONE;
          units_d = elem_units(rom_entry.pattern[load_msb]);
          elem_d  = load_msb;
          pin_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_TONE: begin
        if (elem_last) begin
          state_d = ST_GAP;
          pin_d   = 1'b0;
          units_d = (elem_q == 3'd0) ? UNITS_W'(CHAR_GAP_U) : UNITS_W'(ELEM_GAP_U);
        end else begin
`ifndef BUZZER_DC_TONE_EN
          if (tone_cnt_q == TONE_LAST) begin
            tone_cnt_d = '0;
            pin_d      = ~pin_q;
          end else begin
            tone_cnt_d = tone_cnt_q + TONE_W'(1);
          end
`endif
        end
      end

      ST_GAP: begin
        pin_d = 1'b0;
        if (elem_last) begin
          if (elem_q == 3'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_TONE;
            elem_d  = next_elem;
            units_d = elem_units(pat_q[next_elem]);
            pin_d   = 1'b1;
`ifndef BUZZER_DC_TONE_EN
            tone_cnt_d = '0;
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      pin_q      <= 1'b0;
      unit_cnt_q <= '0;
      units_q    <= '0;
      elem_q     <= '0;
      pat_q      <= '0;
`ifndef BUZZER_DC_TONE_EN
      tone_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      pin_q      <= pin_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      elem_q     <= elem_d;
      pat_q      <= pat_d;
`ifndef BUZZER_DC_TONE_EN
      tone_cnt_q <= tone_cnt_d;
`endif
    end
  end

  assign Read_Req_Sig = req_q;
  assign Busy_Sig     = busy_q;
  assign Pin_Out      = pin_q;

endmodule

// File: tb/tb_buzzer_morse_player.sv
// Scoreboard bench for buzzer_morse_player: each pushed byte queues its
// expected per-cycle Pin_Out trace, consumed from the cycle after its read pulse.
module tb_buzzer_morse_player;

  localparam int U  = 8;
  localparam int TH = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Empty_Sig = 1'b1;
  logic [7:0] FIFO_Read_Data = 8'h00;
  logic       Read_Req_Sig;
  logic       Busy_Sig;
  logic       Pin_Out;

  buzzer_morse_player #(
    .UNIT_CYCLES (U),
    .TONE_HALF   (TH)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .Empty_Sig      (Empty_Sig),
    .FIFO_Read_Data (FIFO_Read_Data),
    .Read_Req_Sig   (Read_Req_Sig),
    .Busy_Sig       (Busy_Sig),
    .Pin_Out        (Pin_Out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic pin;
    logic last;
  } exp_t;

  byte unsigned fifo_q[$];
  exp_t         exp_q[$];
  int           checks = 0;
  int           failures = 0;
  int           rd_pulses = 0;
  bit           in_byte = 1'b0;

  // Non-show-ahead FIFO read port
  always @(posedge CLK) begin
    if (Read_Req_Sig === 1'b1 && fifo_q.size() > 0) begin
      FIFO_Read_Data <= fifo_q.pop_front();
      rd_pulses      <= rd_pulses + 1;
    end
  end

  always @(negedge CLK) Empty_Sig <= (fifo_q.size() == 0);

  function automatic string morse_of(input byte unsigned b);
    case (b)
      8'h41: return ".-";
      8'h44: return "-..";
      8'h45: return ".";
      8'h4B: return "-.-";
      8'h4F: return "---";
      8'h53: return "...";
      8'h54: return "-";
      8'h5A: return "--..";
      8'h30: return "-----";
      8'h35: return ".....";
      8'h39: return "----.";
      default: return "";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic add_low(input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.pin  = 1'b0;
      e.last = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic add_tone(input int units);
    exp_t e;
    for (int k = 0; k < units * U; k++) begin
`ifdef BUZZER_DC_TONE_EN
      e.pin = 1'b1;
`else
      e.pin = (((k / TH) % 2) == 0);
`endif
      e.last = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic push_byte(input byte unsigned b);
    string s;
    exp_t  e;
    fifo_q.push_back(b);
    add_low(2);
    if (b == 8'h1B) begin
      add_tone(10);
      add_low(3 * U);
    end else if (b == 8'h20) begin
      add_low(7 * U);
    end else begin
      s = morse_of(b);
      for (int i = 0; i < s.len(); i++) begin
        add_tone((s[i] == 8'h2D) ? 3 : 1);
        add_low((i == s.len() - 1) ? 3 * U : U);
      end
    end
    e = exp_q.pop_back();
    e.last = 1'b1;
    exp_q.push_back(e);
    $display("push byte=%02h trace_len=%0d", b, exp_q.size());
  endtask

  task automatic tick();
    exp_t e;
    @(negedge CLK);
    if (RST) begin
      exp_q.delete();
      in_byte = 1'b0;
    end else if (in_byte) begin
      e = exp_q.pop_front();
      chk("pin", 32'(Pin_Out), 32'(e.pin));
      chk("busy_in_byte", 32'(Busy_Sig), 32'd1);
      chk("req_in_byte", 32'(Read_Req_Sig), 32'd0);
      if (e.last) in_byte = 1'b0;
    end else begin
      chk("idle_busy", 32'(Busy_Sig), 32'd0);
      chk("idle_pin", 32'(Pin_Out), 32'd0);
      if (Read_Req_Sig === 1'b1) begin
        chk("read_expected", 32'(exp_q.size() != 0), 32'd1);
        in_byte = (exp_q.size() != 0);
      end
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || in_byte || fifo_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, 32'(exp_q.size() == 0 && !in_byte), 32'd1);
    repeat (4) tick();
    $display("%s done checks=%0d reads=%0d", tag, checks, rd_pulses);
  endtask

  initial begin
    int base;
    int n;
    string seq;

    RST = 1'b1;
    repeat (3) tick();
    chk("rst_req", 32'(Read_Req_Sig), 32'd0);
    chk("rst_busy", 32'(Busy_Sig), 32'd0);
    chk("rst_pin", 32'(Pin_Out), 32'd0);
    RST = 1'b0;
    repeat (3) tick();

    // E then D: single dot, then dash-dot-dot; second read only after the first byte ends
    base = rd_pulses;
    push_byte(8'h45);
    push_byte(8'h44);
    wait_drain("e_d_drain");
    chk("e_d_reads", 32'(rd_pulses - base), 32'd2);

    // Attention tone, D, attention tone
    base = rd_pulses;
    push_byte(8'h1B);
    push_byte(8'h44);
    push_byte(8'h1B);
    wait_drain("esc_drain");
    chk("esc_reads", 32'(rd_pulses - base), 32'd3);

    // Word gap followed by unsupported bytes
    base = rd_pulses;
    push_byte(8'h20);
    push_byte(8'h7E);
    push_byte(8'h61);
    wait_drain("space_drain");
    chk("space_reads", 32'(rd_pulses - base), 32'd3);

    // Empty FIFO: nothing happens
    base = rd_pulses;
    repeat (100) tick();
    chk("empty_reads", 32'(rd_pulses - base), 32'd0);

    // Mixed letters, digits and a space
    base = rd_pulses;
    seq = "SOS 90ZKAT5";
    for (int i = 0; i < seq.len(); i++) push_byte(seq[i]);
    wait_drain("mix_drain");
    chk("mix_reads", 32'(rd_pulses - base), 32'(seq.len()));

    // Reset in the middle of the dash of T
    base = rd_pulses;
    push_byte(8'h54);
    n = 0;
    while (!in_byte && n < 20) begin
      tick();
      n++;
    end
    chk("t_read_seen", 32'(in_byte), 32'd1);
    repeat (14) tick();
    chk("t_mid_dash_busy", 32'(in_byte), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();
    chk("t_rst_pin", 32'(Pin_Out), 32'd0);
    chk("t_rst_busy", 32'(Busy_Sig), 32'd0);
    repeat (40) tick();
    chk("t_reads", 32'(rd_pulses - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
